// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and capture state encoding for the piano PWM blocks
package pwm_pkg;

   localparam int PWM_WIDTH = 16;
   localparam logic [PWM_WIDTH-1:0] PWM_SAT = {PWM_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - multi-flop synchronizer with rise/fall detect for async inputs
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic async_in,
   output logic s_out,
   output logic rise_out,
   output logic fall_out
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign s_out    = sync_q[SYNC_STAGES-1];
   assign rise_out = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_out = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high time of an external PWM line, flags stuck lines
module pwm_capture import pwm_pkg::*; #(
   parameter int WIDTH       = PWM_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] cycle_out,
   output logic [WIDTH-1:0] duty_out,
   output logic             valid_out,
   output logic             stuck_out,
   output logic             stuck_level
);

   localparam logic [WIDTH-1:0] SAT = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             s, rise, fall;
   logic             period_sat, timeout;
   pwm_state_e       state_q, state_d;
   logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
   logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [WIDTH-1:0] cycle_q, cycle_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;
   logic             stuck_level_q, stuck_level_d;

   pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .async_in (pwm_in),
      .s_out    (s),
      .rise_out (rise),
      .fall_out (fall)
   );

   assign period_sat = (period_cnt_q == SAT);
   assign timeout    = period_sat & ~rise;

   always_comb begin
      state_d       = state_q;
      cycle_d       = cycle_q;
      duty_d        = duty_q;
      valid_d       = 1'b0;
      stuck_d       = stuck_q;
      stuck_level_d = stuck_level_q;

      // The rising-edge sample is itself the first high clock of the new period.
      if (rise) begin
         period_cnt_d = ONE;
         high_cnt_d   = ONE;
      end else begin
         period_cnt_d = period_sat ? period_cnt_q : period_cnt_q + ONE;
         high_cnt_d   = (s && high_cnt_q != SAT) ? high_cnt_q + ONE : high_cnt_q;
      end

      if (rise) begin
         stuck_d = 1'b0;
         state_d = ST_HIGH;
         if (state_q == ST_LOW) begin
            cycle_d = period_cnt_q;
            duty_d  = high_cnt_q;
            valid_d = 1'b1;
         end
      end else if (timeout) begin
         state_d = ST_SYNC;
         // Level is latched once; a later transition without a rise must not rewrite it.
         if (!stuck_q) begin
            stuck_d       = 1'b1;
            stuck_level_d = s;
         end
      end else if (fall && state_q == ST_HIGH) begin
         state_d = ST_LOW;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= ST_SYNC;
         period_cnt_q  <= '0;
         high_cnt_q    <= '0;
         cycle_q       <= '0;
         duty_q        <= '0;
         valid_q       <= 1'b0;
         stuck_q       <= 1'b0;
         stuck_level_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         period_cnt_q  <= period_cnt_d;
         high_cnt_q    <= high_cnt_d;
         cycle_q       <= cycle_d;
         duty_q        <= duty_d;
         valid_q       <= valid_d;
         stuck_q       <= stuck_d;
         stuck_level_q <= stuck_level_d;
      end
   end

   assign cycle_out   = cycle_q;
   assign duty_out    = duty_q;
   assign valid_out   = valid_q;
   assign stuck_out   = stuck_q;
   assign stuck_level = stuck_level_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the piano PWM generator.
- Samples an external PWM waveform, measures each period (cycle) and high time (duty) in clk_in ticks, and reports every measurement with a one-cycle valid strobe.
- Flags a stuck line, constant high or constant low, after a saturation timeout.
- Used for loopback self-test of the tone outputs and for decoding externally supplied PWM.

Parameters:
WIDTH, 16, bit width of the period/duty counters and outputs; maximum measurable period 2**WIDTH-1 clocks
SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
pwm_in  input  1  asynchronous PWM waveform to measure
cycle_out  output  WIDTH  last measured period in clocks, rising edge to rising edge
duty_out  output  WIDTH  last measured high time in clocks
valid_out  output  1  one-cycle strobe; cycle_out/duty_out updated on the same cycle
stuck_out  output  1  level; line has had no rising edge for 2**WIDTH-1 clocks
stuck_level  output  1  synchronized line level captured when stuck_out asserted

Behaviour:
- Reset (async, rst_n_in=0):
  - Synchronizer flops, edge-history flop, counters, cycle_out, duty_out, valid_out, stuck_out and stuck_level all 0.
  - State = SYNC.
- Input path:
  - pwm_in passes through SYNC_STAGES flops, giving s.
  - Previous value p is kept in one more flop.
  - rise = s & ~p; fall = ~s & p.
  - All decisions below use s, rise and fall.
- Counters:
  - period_cnt and high_cnt are WIDTH bits.
  - On rise, both load 1, so the edge sample counts as the first high clock.
  - Otherwise period_cnt increments every clock, and high_cnt increments while s=1.
  - Both saturate at 2**WIDTH-1 and never wrap.
- States:
  - SYNC: waiting for the first rising edge. Partial periods are never reported. On rise go to HIGH.
  - HIGH: on fall go to LOW.
  - LOW: on rise go to HIGH, and registered in the same clock edge: cycle_out <= period_cnt, duty_out <= high_cnt, valid_out <= 1.
- valid_out:
  - High for exactly one clock, otherwise 0.
  - It is high in the clock following the one where rise is first seen.
  - Total latency from a pwm_in rising edge to valid_out is SYNC_STAGES+1 clocks.
- First report: the first valid_out after reset or after a stuck condition occurs at the second rising edge.
- Timeout:
  - Applies in any state when period_cnt reaches 2**WIDTH-1 with no rise.
  - Next state is SYNC; stuck_out <= 1; stuck_level <= s.
  - No valid_out is issued; cycle_out and duty_out hold their last values.
  - stuck_out clears on the next rise, and the SYNC re-arm rule then applies.
- Simultaneous events: if rise coincides with saturation, rise wins and no stuck is flagged.
- Narrow pulses:
  - A 1-clock high pulse (after synchronization) gives duty_out=1.
  - Pulses shorter than one clock may be missed; this is not an error.
- Full-duty limit: a 100%-duty input has no falling edge and is reported as stuck with stuck_level=1.
- 0%-duty input: reported as stuck with stuck_level=0.
- Reset mid-period: all state is discarded, and the next report requires two fresh rising edges.
- Generator compatibility: a matching generator configured with cycle=N and duty=D (0<D<N) yields cycle_out=N and duty_out=D.

Decomposition:
- Shared package pwm_pkg:
  - state encoding (SYNC, HIGH, LOW, 2 bits)
  - default WIDTH constant, shared with the generator
  - saturation constant 2**WIDTH-1
- One sub-module, pwm_sync_edge:
  - parameter SYNC_STAGES
  - outputs s, rise, fall
  - reusable by other asynchronous key and button inputs of the piano design.
- The FSM and counters stay in pwm_capture.

Test Plan:
- Drive the generator with N=10, D=3 into pwm_in -> first valid_out at the 2nd rising edge, then every 10 clocks, with cycle_out=10 and duty_out=3 each time.
- Change the generator's duty to 7 mid-run -> within two periods, reports cycle_out=10, duty_out=7; no report has a duty value other than 3 or 7.
- N=2, D=1 -> cycle_out=2, duty_out=1, valid_out every other clock.
- Hold pwm_in=0 for 65535 clocks after one rising edge -> no valid_out; stuck_out=1 and stuck_level=0, with outputs held. Then restart the N=10, D=3 waveform -> stuck_out clears at the first rise, and a valid report arrives one period later.
- Hold pwm_in=1 continuously -> stuck_out=1 and stuck_level=1 after saturation.
- Assert rst_n_in for 1 clock mid-HIGH during the N=10, D=3 stream -> all outputs read 0 immediately; the next valid_out comes only after two rising edges, with cycle_out=10 and duty_out=3.
